// File: rtl/adder_pipe_param.sv
// -----------------------------------------------------------------------------
// adder_pipe_param
//
// Pipelined ripple-chunk adder/subtractor. A WIDTH-bit operation is split into
// N = WIDTH/CHUNK chunks; stage k adds chunk k and registers the partial sum
// together with the carry for stage k+1. Every stage carries the full operand
// and result words forward:
//   - the operand chunks not yet added ride along (skew), and
//   - the result chunks already produced ride along (de-skew),
// so the complete sum leaves the last stage in a single cycle.
//
// Parameters
//   WIDTH  operand/result width, must be a multiple of CHUNK
//   CHUNK  bits added per stage (N = WIDTH/CHUNK stages, N >= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand set present on a, b, cin, sub
//   in_ready   operands accepted this cycle (combinational, = advance)
//   a, b       operands
//   cin        carry-in (add) or borrow-in (subtract)
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  result present on sum/cout/ovf
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   cout       raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
//
// Latency is N cycles; throughput one operation per cycle. The whole pipeline
// advances together whenever the output register is empty or being drained.
// -----------------------------------------------------------------------------
module adder_pipe_param #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Guarded so a bad CHUNK cannot cause a divide-by-zero before the
    // parameter check below gets a chance to report it.
    localparam int N = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam bit PARAMS_BAD = (CHUNK < 1) ? 1'b1
                              : (((WIDTH % CHUNK) != 0) || (WIDTH < CHUNK));

    generate
        if (PARAMS_BAD) begin : g_bad_params
            $error("adder_pipe_param: WIDTH must be a non-zero multiple of CHUNK and CHUNK >= 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Entry preprocessing: subtraction is a + ~b + ~borrow_in.
    // -------------------------------------------------------------------------
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? ~cin : cin;

    // -------------------------------------------------------------------------
    // Stage registers (index k holds the state after chunk k has been added)
    // and their next-state values.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] a_reg  [N];
    logic [WIDTH-1:0] b_reg  [N];
    logic [WIDTH-1:0] s_reg  [N];
    logic             c_reg  [N];
    logic             v_reg  [N];

    logic [WIDTH-1:0] a_next [N];
    logic [WIDTH-1:0] b_next [N];
    logic [WIDTH-1:0] s_next [N];
    logic             c_next [N];
    logic             v_next [N];

    logic             ovf_reg;
    logic             ovf_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_stage
            logic [WIDTH-1:0] a_src;
            logic [WIDTH-1:0] b_src;
            logic [WIDTH-1:0] s_src;
            logic             c_src;
            logic             v_src;
            logic [CHUNK:0]   chunk_add;
            logic [WIDTH-1:0] s_merged;

            if (gi == 0) begin : g_head
                // First stage takes operands straight from the ports. A cycle
                // with in_valid=0 while advancing loads a bubble (v_src=0).
                assign a_src = a;
                assign b_src = b_eff;
                assign s_src = '0;
                assign c_src = c0;
                assign v_src = in_valid;
            end else begin : g_body
                assign a_src = a_reg[gi-1];
                assign b_src = b_reg[gi-1];
                assign s_src = s_reg[gi-1];
                assign c_src = c_reg[gi-1];
                assign v_src = v_reg[gi-1];
            end

            // One extra bit on the chunk adder captures the carry for the
            // next stage.
            assign chunk_add = {1'b0, a_src[gi*CHUNK +: CHUNK]}
                             + {1'b0, b_src[gi*CHUNK +: CHUNK]}
                             + {{CHUNK{1'b0}}, c_src};

            // Keep the result chunks produced upstream, insert this one.
            always_comb begin
                s_merged                     = s_src;
                s_merged[gi*CHUNK +: CHUNK]  = chunk_add[CHUNK-1:0];
            end

            assign a_next[gi] = a_src;
            assign b_next[gi] = b_src;
            assign s_next[gi] = s_merged;
            assign c_next[gi] = chunk_add[CHUNK];
            assign v_next[gi] = v_src;
        end
    endgenerate

    // Carry into the MSB is recovered from the MSB sum bit and its operand
    // bits (s = a ^ b ^ c_in). Overflow is that carry XOR the carry out.
    assign ovf_next = (s_next[N-1][WIDTH-1] ^ a_next[N-1][WIDTH-1] ^ b_next[N-1][WIDTH-1])
                    ^ c_next[N-1];

    // -------------------------------------------------------------------------
    // Pipeline registers. Everything shifts together on adv and holds
    // otherwise; reset discards all in-flight work.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                a_reg[k] <= '0;
                b_reg[k] <= '0;
                s_reg[k] <= '0;
                c_reg[k] <= 1'b0;
                v_reg[k] <= 1'b0;
            end
            ovf_reg <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < N; k++) begin
                a_reg[k] <= a_next[k];
                b_reg[k] <= b_next[k];
                s_reg[k] <= s_next[k];
                c_reg[k] <= c_next[k];
                v_reg[k] <= v_next[k];
            end
            ovf_reg <= ovf_next;
        end
    end

    // -------------------------------------------------------------------------
    // Handshake and outputs. in_ready is the only combinational output and
    // depends on out_valid/out_ready alone.
    // -------------------------------------------------------------------------
    assign adv       = !v_reg[N-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_reg[N-1];
    assign sum       = s_reg[N-1];
    assign cout      = c_reg[N-1];
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_adder_pipe_param.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe_param
//
// Directed bench for adder_pipe_param with WIDTH=16, CHUNK=4 (four stages).
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
// Expected results are hand-computed constants in a vector table.
// -----------------------------------------------------------------------------
module tb_adder_pipe_param;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NVEC  = 14;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    adder_pipe_param #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Vector table: operands and hand-computed results.
    logic [WIDTH-1:0] va   [NVEC];
    logic [WIDTH-1:0] vb   [NVEC];
    logic             vc   [NVEC];
    logic             vsub [NVEC];
    logic [WIDTH-1:0] vs   [NVEC];
    logic             vco  [NVEC];
    logic             vov  [NVEC];

    task automatic set_vec(input int i, input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                           input logic ci, input logic si, input logic [WIDTH-1:0] es,
                           input logic eco, input logic eov);
        va[i] = ai; vb[i] = bi; vc[i] = ci; vsub[i] = si;
        vs[i] = es; vco[i] = eco; vov[i] = eov;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        a   = va[i];
        b   = vb[i];
        cin = vc[i];
        sub = vsub[i];
    endtask

    task automatic check_res(input string tag, input int i);
        check({tag, ".sum"},  32'(sum),  32'(vs[i]));
        check({tag, ".cout"}, 32'(cout), 32'(vco[i]));
        check({tag, ".ovf"},  32'(ovf),  32'(vov[i]));
    endtask

    // Send one operation and wait for its result. With four stages the
    // result shows up three edges after the accepting edge (four cycles
    // counting the cycle of the transfer). The result is left on the output.
    task automatic run_single(input string tag, input int i);
        int edges;
        drive(i);
        in_valid = 1'b1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 10) begin
            tick();
            edges++;
        end
        check({tag, ".latency"}, 32'(edges), 32'd3);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check_res(tag, i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_cyc;
        int last_cyc;
        int out_idx;
        int got;
        int spurious;
        int bp_exp [3];

        // idx: a, b, cin, sub -> sum, cout, ovf
        set_vec(0,  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0); // carry into chunk 2
        set_vec(1,  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0); // full ripple
        set_vec(2,  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); // sub overflow
        set_vec(3,  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0); // sub borrow
        set_vec(4,  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); // add overflow
        set_vec(5,  16'h0010, 16'h0005, 1'b1, 1'b1, 16'h000A, 1'b1, 1'b0); // borrow-in
        set_vec(6,  16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        set_vec(7,  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        set_vec(8,  16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        set_vec(9,  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        set_vec(10, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        set_vec(11, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        set_vec(12, 16'hABCD, 16'h1234, 1'b1, 1'b1, 16'h9998, 1'b1, 1'b0);
        set_vec(13, 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.sum",       32'(sum),       32'd0);
        check("reset.cout",      32'(cout),      32'd0);
        check("reset.ovf",       32'(ovf),       32'd0);
        rst = 1'b0;
        #1;
        check("reset.in_ready",  32'(in_ready),  32'd1);

        // Single operations
        run_single("add_00ff_1",   0);
        run_single("ripple_ffff",  1);
        run_single("sub_8000_1",   2);
        run_single("sub_3_5",      3);
        run_single("add_ovf",      4);
        run_single("sub_borrowin", 5);

        // Back-to-back stream of 8 operations
        first_cyc = -1; last_cyc = -1; out_idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 8) begin
                drive(6 + c);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                if (out_idx < 8) check_res($sformatf("stream[%0d]", out_idx), 6 + out_idx);
                out_idx++;
            end
        end
        in_valid = 1'b0;
        check("stream.first_cycle", 32'(first_cyc), 32'd3);
        check("stream.count",       32'(out_idx),   32'd8);
        check("stream.span",        32'(last_cyc - first_cyc), 32'd7);

        // Backpressure: A, B, C in flight, D offered during the stall
        drive(8);  in_valid = 1'b1; tick();
        drive(11); tick();
        drive(12); tick();
        in_valid = 1'b0; tick();
        check("bp.head_valid", 32'(out_valid), 32'd1);
        check("bp.head_sum",   32'(sum),       32'(vs[8]));
        out_ready = 1'b0;
        drive(0); in_valid = 1'b1;
        #1;
        check("bp.in_ready_stall", 32'(in_ready), 32'd0);
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("bp.stall%0d.valid", s),    32'(out_valid), 32'd1);
            check($sformatf("bp.stall%0d.sum", s),      32'(sum),       32'(vs[8]));
            check($sformatf("bp.stall%0d.in_ready", s), 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_release", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        bp_exp[0] = 11; bp_exp[1] = 12; bp_exp[2] = 0;
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (out_valid) begin
                check_res($sformatf("bp.resume[%0d]", got), bp_exp[got]);
                got++;
            end
            tick();
        end
        check("bp.resume_count", 32'(got), 32'd3);
        repeat (4) tick();
        check("bp.drained", 32'(out_valid), 32'd0);

        // Asynchronous reset with three operations in flight
        drive(6);  in_valid = 1'b1; tick();
        drive(8);  tick();
        drive(12); tick();
        in_valid = 1'b0; tick();
        check("rst.pre_valid", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("rst.async_valid", 32'(out_valid), 32'd0);
        check("rst.async_sum",   32'(sum),       32'd0);
        check("rst.async_cout",  32'(cout),      32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) spurious++;
        end
        check("rst.no_stale", 32'(spurious), 32'd0);
        run_single("rst.fresh", 7);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
